data_bus_ctrl: RTL and testbench

//  Sits directly downstream of the CPU data port, in the MEM stage.

---
 rtl/data_bus_ctrl_pkg.sv | 20 ++
 rtl/data_bus_ctrl_if.sv | 25 ++
 rtl/data_bus_ctrl_uart_tx_unit.sv | 100 ++++++++++
 rtl/data_bus_ctrl.sv | 90 +++++++++
 tb/tb_data_bus_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/data_bus_ctrl_pkg.sv
// Shared definitions for the MEM-stage data bus controller: IO window offsets,
// UART transmitter state encoding and the default IO window base.
package data_bus_ctrl_pkg;

  localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

  // Word offsets inside the 16-byte IO window; byte lanes 1-3 alias lane 0.
  localparam logic [3:0] IO_LED   = 4'h0;
  localparam logic [3:0] IO_UART  = 4'h4;
  localparam logic [3:0] IO_CYCLE = 4'h8;
  localparam logic [3:0] IO_CTRL  = 4'hC;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/data_bus_ctrl_if.sv
// CPU data port plus data RAM port as seen by the bus controller.
// master = CPU/RAM side, slave = the controller.
interface data_bus_ctrl_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] cpuAddr;
  logic [DATA_WIDTH-1:0] cpuWrData;
  logic                  cpuWrEnable;
  logic [DATA_WIDTH-1:0] cpuRdData;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWrData;
  logic                  memWrEnable;
  logic [DATA_WIDTH-1:0] memRdData;

  modport master (
    output cpuAddr, cpuWrData, cpuWrEnable, memRdData,
    input  cpuRdData, memAddr, memWrData, memWrEnable
  );

  modport slave (
    input  cpuAddr, cpuWrData, cpuWrEnable, memRdData,
    output cpuRdData, memAddr, memWrData, memWrEnable
  );
endinterface

// File: rtl/data_bus_ctrl_uart_tx_unit.sv
// 8N1 UART transmitter: baud counter, bit index, shift register and FSM.
// start is only honoured in IDLE; busy is high for the whole frame including STOP.
module uart_tx_unit
  import data_bus_ctrl_pkg::*;
#(
  parameter int BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byteIn,
  output logic       busy,
  output logic       txOut
);
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  uart_state_e state, stateNext;
  logic [15:0] baudCnt, baudNext;
  logic [2:0]  bitIdx, bitNext;
  logic [7:0]  shiftReg, shiftNext;
  logic        txReg, txNext;
  logic        baudEnd;

  assign baudEnd = (baudCnt == BAUD_LAST);
  assign busy    = (state != UART_IDLE);
  assign txOut   = txReg;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= UART_IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
    end else begin
      state    <= stateNext;
      baudCnt  <= baudNext;
      bitIdx   <= bitNext;
      shiftReg <= shiftNext;
      txReg    <= txNext;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext = state;
    baudNext  = baudCnt;
    bitNext   = bitIdx;
    shiftNext = shiftReg;
    txNext    = txReg;
    case (state)
      UART_IDLE: begin
        txNext = 1'b1;
        if (start) begin
          stateNext = UART_START;
          baudNext  = '0;
          shiftNext = byteIn;
          txNext    = 1'b0;
        end
      end
      UART_START: begin
        if (baudEnd) begin
          stateNext = UART_DATA;
          baudNext  = '0;
          bitNext   = '0;
          txNext    = shiftReg[0];
        end else begin
          baudNext = baudCnt + 16'd1;
        end
      end
      UART_DATA: begin
        if (baudEnd) begin
          baudNext = '0;
          if (bitIdx == 3'd7) begin
            stateNext = UART_STOP;
            txNext    = 1'b1;
          end else begin
            bitNext   = bitIdx + 3'd1;
            shiftNext = {1'b0, shiftReg[7:1]};
            txNext    = shiftReg[1];
          end
        end else begin
          baudNext = baudCnt + 16'd1;
        end
      end
      UART_STOP: begin
        txNext = 1'b1;
        if (baudEnd) begin
          stateNext = UART_IDLE;
          baudNext  = '0;
        end else begin
          baudNext = baudCnt + 16'd1;
        end
      end
      default: stateNext = UART_IDLE;
    endcase
  end
endmodule

// File: rtl/data_bus_ctrl.sv
// MEM-stage data bus controller: splits CPU data accesses between data RAM and a
// 16-byte IO window (LED, UART, cycle counter). UART built only with DATA_BUS_CTRL_UART_EN.
module data_bus_ctrl
  import data_bus_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = IO_BASE_DEFAULT,
  parameter int                    BAUD_DIV   = 434
) (
  input  logic                 clk,
  input  logic                 rst,
  data_bus_ctrl_if.slave       bus,
  output logic [7:0]           ledOut,
  output logic                 uartTx
);
  if ((BAUD_DIV < 2) || (BAUD_DIV > 65535)) begin : gBadBaudDiv
    $error("data_bus_ctrl: BAUD_DIV out of range 2..65535");
  end

  logic                  ioHit;
  logic                  ioWr;
  logic [3:0]            ioOffset;
  logic [DATA_WIDTH-1:0] ioRd;
  logic [7:0]            led;
  logic [31:0]           cycleCnt;
  logic                  uartBusy;
  logic                  overrun;

  assign ioHit    = (bus.cpuAddr[ADDR_WIDTH-1:4] == IO_BASE[ADDR_WIDTH-1:4]);
  assign ioWr     = bus.cpuWrEnable & ioHit;
  assign ioOffset = bus.cpuAddr[3:0] & 4'hC;

  assign bus.memAddr     = bus.cpuAddr;
  assign bus.memWrData   = bus.cpuWrData;
  assign bus.memWrEnable = bus.cpuWrEnable & ~ioHit;
  assign bus.cpuRdData   = ioHit ? ioRd : bus.memRdData;
  assign ledOut          = led;

  always_ff @(posedge clk) begin
    if (!rst) begin
      led      <= '0;
      cycleCnt <= '0;
    end else begin
      if (ioWr && (ioOffset == IO_LED)) led <= bus.cpuWrData[7:0];
      // A load takes priority over the increment in the same cycle.
      if (ioWr && (ioOffset == IO_CYCLE)) cycleCnt <= bus.cpuWrData[31:0];
      else                                cycleCnt <= cycleCnt + 32'd1;
    end
  end

`ifdef DATA_BUS_CTRL_UART_EN
  logic uartStart;

  assign uartStart = ioWr && (ioOffset == IO_UART) && !uartBusy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun <= 1'b0;
    end else if (ioWr && (ioOffset == IO_CTRL)) begin
      overrun <= 1'b0;
    end else if (ioWr && (ioOffset == IO_UART) && uartBusy) begin
      overrun <= 1'b1;
    end
  end

  uart_tx_unit #(.BAUD_DIV(BAUD_DIV)) uUart (
    .clk   (clk),
    .rst   (rst),
    .start (uartStart),
    .byteIn(bus.cpuWrData[7:0]),
    .busy  (uartBusy),
    .txOut (uartTx)
  );
`else
  assign uartBusy = 1'b0;
  assign overrun  = 1'b0;
  assign uartTx   = 1'b1;
`endif

  always_comb begin
    ioRd = '0;
    case (ioOffset)
      IO_LED:   ioRd = DATA_WIDTH'(led);
      IO_UART:  ioRd = DATA_WIDTH'({overrun, uartBusy});
      IO_CYCLE: ioRd = DATA_WIDTH'(cycleCnt);
      default:  ioRd = '0;
    endcase
  end
endmodule

// File: tb/tb_data_bus_ctrl.sv
// Directed bench for data_bus_ctrl (BAUD_DIV=4, IO_BASE=16'hFF00); read data goes
// through an expected-value queue. UART steps follow DATA_BUS_CTRL_UART_EN.
module tb_data_bus_ctrl;
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ledOut;
  logic       uartTx;
  int         nChecks = 0;
  int         nErrors = 0;
  exp_t       expQ[$];

  data_bus_ctrl_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  data_bus_ctrl #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .IO_BASE   (16'hFF00),
    .BAUD_DIV  (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .ledOut(ledOut),
    .uartTx(uartTx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChecks++;
    assert (obs === expv) else begin
      nErrors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic popCheck();
    exp_t e;
    if (expQ.size() == 0) begin
      nChecks++;
      nErrors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", bus.cpuRdData);
    end else begin
      e = expQ.pop_front();
      check(e.tag, bus.cpuRdData, e.val);
    end
  endtask

  // One bus cycle: drive at the falling edge, check read data 1 ns later.
  task automatic step(input logic [15:0] a, input logic [31:0] d, input logic we,
                      input string tag, input logic [31:0] expRd);
    @(negedge clk);
    bus.cpuAddr     = a;
    bus.cpuWrData   = d;
    bus.cpuWrEnable = we;
    expQ.push_back('{tag: tag, val: expRd});
    #1;
    popCheck();
  endtask

  // Extra combinational read within the current cycle.
  task automatic peek(input logic [15:0] a, input string tag, input logic [31:0] expRd);
    bus.cpuAddr = a;
    expQ.push_back('{tag: tag, val: expRd});
    #1;
    popCheck();
  endtask

  function automatic logic frameBit(input logic [7:0] b, input int slot);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    return 1'b1;
  endfunction

  initial begin
    rst             = 1'b0;
    bus.cpuAddr     = 16'h0010;
    bus.cpuWrData   = '0;
    bus.cpuWrEnable = 1'b0;
    bus.memRdData   = 32'hDEADBEEF;
    repeat (2) @(negedge clk);

    // Reset state
    peek(16'hFF08, "rst_counter", 32'h0);
    peek(16'hFF00, "rst_led_rd", 32'h0);
    peek(16'hFF04, "rst_status", 32'h0);
    check("rst_ledOut", 32'(ledOut), 32'h0);
    check("rst_uartTx", 32'(uartTx), 32'h1);
    rst = 1'b1;

    // RAM store then load
    step(16'h0010, 32'h12345678, 1'b1, "ram_wr_rd", 32'hDEADBEEF);
    check("ram_memWrEnable", 32'(bus.memWrEnable), 32'h1);
    check("ram_memAddr", 32'(bus.memAddr), 32'h0010);
    check("ram_memWrData", bus.memWrData, 32'h12345678);
    step(16'h0010, 32'h0, 1'b0, "ram_rd", 32'hDEADBEEF);
    check("ram_memWrEnable_off", 32'(bus.memWrEnable), 32'h0);
    check("ram_led_unchanged", 32'(ledOut), 32'h0);
    check("ram_tx_idle", 32'(uartTx), 32'h1);
    bus.memRdData = 32'h0BADF00D;
    peek(16'h0010, "ram_rd_passthru", 32'h0BADF00D);
    peek(16'hFEFC, "ram_below_window", 32'h0BADF00D);

    // LED register, including byte-lane aliasing
    step(16'hFF00, 32'h000000A5, 1'b1, "led_wr_rd_old", 32'h0);
    check("led_memWrEnable", 32'(bus.memWrEnable), 32'h0);
    step(16'hFF00, 32'h0, 1'b0, "led_rd", 32'h000000A5);
    check("led_out", 32'(ledOut), 32'hA5);
    peek(16'hFF03, "led_alias_rd", 32'h000000A5);
    step(16'hFF01, 32'hFFFFFF3C, 1'b1, "led_alias_wr", 32'h000000A5);
    step(16'hFF00, 32'h0, 1'b0, "led_rd2", 32'h0000003C);
    check("led_out2", 32'(ledOut), 32'h3C);

    // Cycle counter load and wrap
    @(negedge clk);
    bus.cpuAddr = 16'hFF08; bus.cpuWrData = 32'hFFFFFFFE; bus.cpuWrEnable = 1'b1;
    #1;
    check("cyc_memWrEnable", 32'(bus.memWrEnable), 32'h0);
    step(16'hFF08, 32'h0, 1'b0, "cyc_loaded", 32'hFFFFFFFE);
    step(16'hFF08, 32'h0, 1'b0, "cyc_max", 32'hFFFFFFFF);
    step(16'hFF08, 32'h0, 1'b0, "cyc_wrap", 32'h00000000);
    step(16'hFF08, 32'h0, 1'b0, "cyc_after_wrap", 32'h00000001);
    step(16'hFF0C, 32'h0, 1'b0, "ctrl_rd", 32'h0);

`ifdef DATA_BUS_CTRL_UART_EN
    // Single frame of 0x55; a write in the last STOP cycle is dropped as overrun
    step(16'hFF04, 32'h55, 1'b1, "tx1_status_pre", 32'h0);
    for (int k = 0; k < 40; k++) begin
      step(16'hFF04, (k == 39) ? 32'hAA : 32'h0, (k == 39), $sformatf("tx1_status_%0d", k), 32'h1);
      check($sformatf("tx1_bit_%0d", k), 32'(uartTx), 32'(frameBit(8'h55, k / 4)));
    end
    step(16'hFF04, 32'h0, 1'b0, "tx1_late_overrun", 32'h2);
    check("tx1_idle_tx", 32'(uartTx), 32'h1);
    step(16'hFF0C, 32'h0, 1'b1, "tx1_ctrl_clr", 32'h0);
    check("tx1_late_dropped", 32'(uartTx), 32'h1);
    step(16'hFF04, 32'h0, 1'b0, "tx1_status_clr", 32'h0);

    // 0x55 then 0x33 one cycle apart; clear overrun mid-frame
    step(16'hFF04, 32'h55, 1'b1, "tx2_status_pre", 32'h0);
    for (int k = 0; k < 40; k++) begin
      if (k == 0)      step(16'hFF04, 32'h33, 1'b1, "tx2_status_k0", 32'h1);
      else if (k == 1) step(16'hFF04, 32'h0, 1'b0, "tx2_status_ovr", 32'h3);
      else if (k == 2) step(16'hFF0C, 32'h12, 1'b1, "tx2_ctrl_rd", 32'h0);
      else             step(16'hFF04, 32'h0, 1'b0, $sformatf("tx2_status_%0d", k), 32'h1);
      check($sformatf("tx2_bit_%0d", k), 32'(uartTx), 32'(frameBit(8'h55, k / 4)));
    end

    // First IDLE cycle accepts the next byte; reset lands during data bit 3
    step(16'hFF04, 32'h0F, 1'b1, "tx3_status_idle", 32'h0);
    check("tx3_idle_tx", 32'(uartTx), 32'h1);
    for (int k = 0; k < 17; k++) begin
      step(16'hFF04, 32'h0, 1'b0, $sformatf("tx3_status_%0d", k), 32'h1);
      check($sformatf("tx3_bit_%0d", k), 32'(uartTx), 32'(frameBit(8'h0F, k / 4)));
    end
`else
    // UART absent: the frame write is ignored
    step(16'hFF04, 32'h55, 1'b1, "nouart_status_pre", 32'h0);
    check("nouart_memWrEnable", 32'(bus.memWrEnable), 32'h0);
    for (int k = 0; k < 40; k++) begin
      step(16'hFF04, 32'h0, 1'b0, $sformatf("nouart_status_%0d", k), 32'h0);
      check($sformatf("nouart_tx_%0d", k), 32'(uartTx), 32'h1);
    end
    step(16'hFF0C, 32'h0, 1'b1, "nouart_ctrl_rd", 32'h0);
`endif

    // One-cycle reset; RAM write strobe still follows cpuWrEnable
    @(negedge clk);
    rst = 1'b0;
    bus.cpuAddr = 16'h0020; bus.cpuWrData = 32'hCAFE0001; bus.cpuWrEnable = 1'b1;
    #1;
    check("rst_memWrEnable", 32'(bus.memWrEnable), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    bus.cpuWrEnable = 1'b0;
    peek(16'hFF08, "rst2_counter", 32'h0);
    peek(16'hFF04, "rst2_status", 32'h0);
    check("rst2_uartTx", 32'(uartTx), 32'h1);
    check("rst2_ledOut", 32'(ledOut), 32'h0);
    for (int k = 0; k < 8; k++) begin
      step(16'hFF04, 32'h0, 1'b0, $sformatf("rst2_status_%0d", k), 32'h0);
      check($sformatf("rst2_tx_%0d", k), 32'(uartTx), 32'h1);
    end
    step(16'hFF08, 32'h0, 1'b0, "rst2_counter_run", 32'd9);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule
